// File: rtl/zc_period_avg_if.sv
// One-beat AXI-stream link carrying signed half-period counts or their averages.
interface zc_period_avg_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tlast;
   logic             tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/zc_period_avg.sv
// Averages 2^len signed zero-crossing half-period counts into one output beat,
// discarding partial windows that go stale.
module zc_period_avg #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ACC_EXTRA = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [3:0]           log_avg_len,
   input  logic [31:0]          timeout,
   zc_period_avg_if.slave       s_axis,
   zc_period_avg_if.master      m_axis,
   output logic                 stale,
   output logic [15:0]          fill,
   output logic [15:0]          timeout_cnt
);
   localparam int unsigned AW = WIDTH + ACC_EXTRA;
   localparam int unsigned LW = $clog2(ACC_EXTRA + 2);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t               state_q, state_n;
   logic signed [AW-1:0] acc_q, acc_n, in_sext, acc_sum;
   logic [LW-1:0]        len_q, len_n, len_clamp;
   logic [16:0]          fill_inc, win_len;
   logic [15:0]          fill_q, fill_n, tcnt_q, tcnt_n;
   logic [31:0]          timer_q, timer_n;
   logic [WIDTH-1:0]     odata_q, odata_n;
   logic                 stale_q, stale_n, rdy_q, valid_q, accept;
   logic                 unused_tlast;

   assign unused_tlast  = s_axis.tlast;
   assign accept        = s_axis.tvalid & rdy_q;
   assign in_sext       = AW'(signed'(s_axis.tdata));
   assign acc_sum       = acc_q + in_sext;
   assign fill_inc      = 17'(fill_q) + 17'd1;
   assign win_len       = 17'd1 << len_q;
   assign len_clamp     = (32'(log_avg_len) > ACC_EXTRA) ? LW'(ACC_EXTRA) : LW'(log_avg_len);

   assign s_axis.tready = rdy_q;
   assign m_axis.tdata  = odata_q;
   assign m_axis.tvalid = valid_q;
   assign m_axis.tlast  = valid_q;
   assign stale         = stale_q;
   assign fill          = fill_q;
   assign timeout_cnt   = tcnt_q;

   // Next-state and datapath updates
   always_comb begin
      state_n = state_q;
      acc_n   = acc_q;
      len_n   = len_q;
      fill_n  = fill_q;
      timer_n = timer_q;
      odata_n = odata_q;
      stale_n = stale_q;
      tcnt_n  = tcnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               len_n   = len_clamp;
               timer_n = 32'd0;
               if (len_clamp == LW'(0)) begin
                  state_n = HOLD;
                  odata_n = s_axis.tdata;
                  acc_n   = '0;
                  fill_n  = 16'd0;
               end else begin
                  state_n = ACCUM;
                  acc_n   = in_sext;
                  fill_n  = 16'd1;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               timer_n = 32'd0;
               if (fill_inc == win_len) begin
                  state_n = HOLD;
                  odata_n = WIDTH'(acc_sum >>> len_q);
                  acc_n   = '0;
                  fill_n  = 16'd0;
               end else begin
                  acc_n  = acc_sum;
                  fill_n = 16'(fill_inc);
               end
            end else if ((timeout != 32'd0) && (timer_q == timeout - 32'd1)) begin
               // Crossings stopped arriving: drop the partial window
               state_n = IDLE;
               acc_n   = '0;
               fill_n  = 16'd0;
               timer_n = 32'd0;
               stale_n = 1'b1;
               tcnt_n  = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
            end else begin
               timer_n = timer_q + 32'd1;
            end
         end
         HOLD: begin
            if (m_axis.tready) begin
               state_n = IDLE;
               timer_n = 32'd0;
               stale_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q <= IDLE;
         acc_q   <= '0;
         len_q   <= '0;
         fill_q  <= 16'd0;
         timer_q <= 32'd0;
         odata_q <= '0;
         stale_q <= 1'b1;
         rdy_q   <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_n;
         acc_q   <= acc_n;
         len_q   <= len_n;
         fill_q  <= fill_n;
         timer_q <= timer_n;
         odata_q <= odata_n;
         stale_q <= stale_n;
         rdy_q   <= (state_n != HOLD);
         valid_q <= (state_n == HOLD);
      end
   end

   // Timeout count survives a soft clear
   always_ff @(posedge clk) begin
      if (reset)
         tcnt_q <= 16'd0;
      else if (!clear)
         tcnt_q <= tcnt_n;
   end
endmodule

// File: doc/zc_period_avg.md
# zc_period_avg

Averages the signed half-period sample counts produced by the zero-crossing detector in the doppler tracker, giving a lower-variance Doppler period estimate. It consumes the detector's AXI-stream count output and accumulates 2^log_avg_len accepted counts. It then emits one signed average per window on an AXI-stream output to the tracker's frequency/loop logic. A timeout discards stale partial windows when crossings stop arriving.

## Interface
- WIDTH, 32, width of input/output signed counts
- ACC_EXTRA, 16, extra accumulator bits (accumulator width WIDTH+ACC_EXTRA)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous soft clear of datapath/state; same effect as reset except timeout_cnt is preserved
- log_avg_len  in  4  log2 of window length N; 0..15; clamped to ACC_EXTRA if larger
- timeout  in  32  max idle clk cycles between accepted inputs within a window; 0 disables
- i_tdata  in  WIDTH  signed half-period count (negative = negative frequency)
- i_tvalid  in  1  input valid
- i_tlast  in  1  ignored
- i_tready  out  1  input ready
- o_tdata  out  WIDTH  signed window average
- o_tvalid  out  1  output valid
- o_tlast  out  1  high whenever o_tvalid (one-beat packets)
- o_tready  in  1  output ready
- stale  out  1  no average emitted since reset/clear/last timeout
- fill  out  16  accepted samples in current window
- timeout_cnt  out  16  saturating count of timeouts; cleared only by reset

## Operation
- States: IDLE (window empty), ACCUM (0 < fill < N), HOLD (result registered, awaiting o_tready).
- i_tready = 1 in IDLE/ACCUM, 0 in HOLD; input beat accepted when i_tvalid & i_tready.
- IDLE + accept: latch len_l = min(log_avg_len, ACC_EXTRA); acc = sext(i_tdata); fill = 1. If N = 1<<len_l == 1, go to HOLD directly, else go to ACCUM.
- ACCUM + accept: acc += sext(i_tdata); fill++. When the new fill == N, go to HOLD; o_tdata = (acc_new >>> len_l)[WIDTH-1:0], arithmetic shift, floor rounding; acc = 0, fill = 0.
- HOLD: o_tvalid = 1, o_tdata stable; on o_tready go to IDLE, stale = 0.
- log_avg_len changes take effect only at the next window start.
- Timer: reset to 0 on every accept and on entry to IDLE/ACCUM. It increments each cycle in ACCUM without an accept.
  - If timeout != 0 and timer == timeout-1 with no accept that cycle: acc = 0, fill = 0, go to IDLE, stale = 1, timeout_cnt++ (saturate 0xFFFF).
  - An accept in the same cycle wins; no timeout.
- Timer does not run in IDLE or HOLD.
- Accumulator is wide enough for 2^ACC_EXTRA full-scale inputs; no overflow handling is required.

## Timing
- Reset/clear values:
  - state IDLE, acc 0, fill 0, timer 0, o_tvalid 0, o_tdata 0, stale 1, i_tready 1.
  - timeout_cnt: 0 on reset, held on clear.
- Latency: Nth sample accepted at cycle t; o_tvalid high at t+1. i_tready low from t+1 until the cycle after the o_tready handshake.
- o_tdata/o_tvalid are registered; o_tdata is held while o_tvalid & !o_tready.
- Reset or clear during HOLD drops the pending output; o_tvalid is 0 the next cycle.
- fill reads N-1 max during ACCUM; it reads 0 in HOLD and IDLE.

## Test plan
- log_avg_len=2, inputs 10,12,14,16 back-to-back, o_tready=1 -> single output 13 one cycle after 4th accept; stale falls with handshake; fill 1,2,3,0.
- log_avg_len=1, inputs -5,-6 -> output -6 (floor of -5.5); inputs 5,6 -> output 5.
- log_avg_len=0, inputs 7,-7,3 with o_tready=1 -> outputs 7,-7,3, each 1 cycle after accept. i_tready toggles 1,0,1 per sample.
- log_avg_len=2, o_tready=0 after window completes for 20 cycles -> o_tvalid held, o_tdata stable, i_tready=0 throughout; after o_tready=1 the next window accepts.
- timeout=8, log_avg_len=3, 3 samples then silence -> at 8th idle cycle fill=0, stale=1, timeout_cnt=1, no output. Repeat with a sample arriving exactly on the 8th cycle -> no timeout, fill=4.
- Assert clear mid-window (fill=5) and in HOLD -> fill=0, o_tvalid=0 next cycle, stale=1, timeout_cnt unchanged.
